latch_word_serializer: RTL
==========================

# latch_word_serializer

Read side of the gated-latch storage path. Samples the parallel word held on the latch bank's `q` outputs on a start request, then shifts it out one bit at a time over a valid/ready serial handshake, LSB first. Sits between the latch storage stage and any bit-serial consumer (checker, transmitter, display shifter).

## Interface
Parameters:
- `WIDTH`, 8: bits per captured word; legal range 2..32.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `r`  in  1: reset, synchronous, active-high.
- `start`  in  1: capture request; honoured only in IDLE.
- `par_in`  in  WIDTH: word from the latch bank `q` outputs; sampled only on an accepted `start`.
- `ser_out`  out  1: current serial bit.
- `ser_valid`  out  1: `ser_out` holds a valid bit.
- `ser_ready`  in  1: consumer accepts the bit at this edge when `ser_valid` is also high.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the final bit is accepted.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: at an edge with `start`=1. `shreg` <= `par_in`, `cnt` <= 0.
- SHIFT:
  - `ser_out` = `shreg[0]`, `ser_valid` = 1.
  - On each edge with `ser_ready`=1: `shreg` >>= 1 with zero fill, `cnt` += 1.
  - With `ser_ready`=0, `shreg` and `cnt` hold and `ser_out` is stable. A bit is never dropped or repeated.
- SHIFT -> DONE: on the edge that accepts the last bit, i.e. at `cnt` = NBITS-1.
  - NBITS = WIDTH, or WIDTH+1 with parity enabled.
- DONE -> IDLE: unconditionally after one cycle. `done`=1 only in DONE.
- `start` in SHIFT or DONE is ignored and not queued. `start` in the IDLE cycle that follows DONE is accepted normally.
- `par_in` changes after capture have no effect on the word in flight.
- `cnt` width is $clog2(WIDTH+2). It never wraps, because it is cleared on entry to SHIFT.
- `ser_out`=0 whenever `ser_valid`=0.

## Timing
- Reset (`r`=1 at an edge): state=IDLE, `shreg`=0, `cnt`=0. This takes priority over every other input, including mid-SHIFT. From the next cycle, `ser_out`=0, `ser_valid`=0, `busy`=0, `done`=0.
- Latency:
  - `start` edge to first `ser_valid`: 1 cycle.
  - Minimum word time with `ser_ready` held high: NBITS cycles in SHIFT + 1 cycle in DONE.
  - Back-to-back minimum period: NBITS+2 cycles.
- All outputs are registered or decoded from state and registers only. There is no combinational path from `ser_ready` or `start` to any output.
- `start` and `r` both high at the same edge: reset wins, no capture.

## Configuration
- `LATCH_SER_PARITY_EN` defined:
  - After the WIDTH data bits, one extra bit is sent. It is the even parity (XOR) of the captured word, computed at capture and held in its own flop.
  - NBITS = WIDTH+1.
- `LATCH_SER_PARITY_EN` not defined: exactly WIDTH bits are sent, NBITS = WIDTH, and no parity flop exists.

## Structure
- Shared package `latch_ser_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT, DONE}.
  - constant `LATCH_SER_MAX_WIDTH` = 32.
- One sub-module, `ser_bit_counter`:
  - clear, enable, terminal-count compare against NBITS-1, `last` output.
  - Instanced once and driven by the FSM.
- The shift register and FSM stay in the top module.

## Test plan
- Reset mid-word: start with `par_in`=8'hFF, accept 3 bits, assert `r` one cycle -> next cycle `busy`=0, `ser_valid`=0, `ser_out`=0, no `done`.
- Basic word: WIDTH=8, `par_in`=8'hA5, `start` one cycle, `ser_ready`=1 -> `ser_out` sequence 1,0,1,0,0,1,0,1 over 8 cycles, then `done`=1 for exactly 1 cycle, `busy` low the cycle after.
- Backpressure: `par_in`=8'h3C, `ser_ready` toggling 1,0,0,1,... -> received bits still 0,0,1,1,1,1,0,0; `ser_out` is stable during every stall cycle.
- Ignored start: pulse `start` with `par_in`=8'h00 during SHIFT of 8'hC3 -> output remains 1,1,0,0,0,0,1,1; no second word follows.
- Capture isolation: start with 8'h81, change `par_in` to 8'h7E on the next cycle -> output is 1,0,0,0,0,0,0,1.
- Parity (macro defined): `par_in`=8'h07 -> 9 bits 1,1,1,0,0,0,0,0,1. With 8'h03 -> final bit 0, and `done` arrives 10 cycles after start with `ser_ready`=1.

Source files
------------

// File: rtl/latch_ser_pkg.sv
// Shared types and limits for the latch-bank word serializer.
package latch_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ser_state_t;

   localparam int LATCH_SER_MAX_WIDTH = 32;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for the serializer: clear, count-enable and terminal-count flag.
module ser_bit_counter
   import latch_ser_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int LAST_CNT = 7
) (
   input  logic             clk,
   input  logic             r,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_W'(LAST_CNT));

endmodule

// File: rtl/latch_word_serializer.sv
// Captures a latch-bank word on start and shifts it out LSB first over valid/ready.
// Define LATCH_SER_PARITY_EN to append an even-parity bit after the data bits.
module latch_word_serializer
   import latch_ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             r,
   input  logic             start,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             busy,
   output logic             done
);

`ifdef LATCH_SER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CNT_W = $clog2(WIDTH + 2);

   if (WIDTH < 2 || WIDTH > LATCH_SER_MAX_WIDTH) begin : g_bad_width
      $error("latch_word_serializer: WIDTH out of range");
   end

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_en;
   logic             last;
   logic             tx_bit;
   logic             par_bit;
   logic             accept_start;

   assign accept_start = (state_q == IDLE) && start;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               shreg_d = par_in;
               cnt_clr = 1'b1;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               shreg_d = shreg_q >> 1;
               cnt_en  = 1'b1;
               if (last) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

`ifdef LATCH_SER_PARITY_EN
   // Parity is frozen at capture so later par_in changes cannot disturb it.
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (accept_start) begin
         par_d = ^par_in;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign par_bit = par_q;
`else
   assign par_bit = 1'b0;
`endif

   ser_bit_counter #(
      .CNT_W   (CNT_W),
      .LAST_CNT(NBITS - 1)
   ) u_bit_counter (
      .clk (clk),
      .r   (r),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .last(last)
   );

   // Data bits come from the shift register; once WIDTH bits are out, the parity bit follows.
   assign tx_bit    = (cnt < CNT_W'(WIDTH)) ? shreg_q[0] : par_bit;
   assign ser_valid = (state_q == SHIFT);
   assign ser_out   = ser_valid & tx_bit;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule
